// File: rtl/sha256_round_ctrl_pkg.sv
// Shared definitions for the SHA-256 round controller slice.
//   SHA256_ROUNDS : rounds per 512-bit block
//   SHA256_IDX_W  : round index width
//   SHA256_LAG    : cycles from round_idx to registered Wi/Ki
//   state_t       : controller FSM states
package sha256_pkg;

  localparam int unsigned SHA256_ROUNDS = 64;
  localparam int unsigned SHA256_IDX_W  = 6;
  localparam int unsigned SHA256_LAG    = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ROUNDS,
    ST_DRAIN,
    ST_FINAL,
    ST_DONE
  } state_t;

endpackage

// File: rtl/sha256_round_ctrl_if.sv
// Handshake / datapath-control bundle between the round controller and its
// surroundings (block FIFO/padder upstream, schedule + compression downstream,
// digest consumer).
//   master : controller side (drives in_ready, schedule/compression controls,
//            digest_add, out_valid)
//   slave  : environment side (drives in_valid, in_first, out_ready[, abort])
// Optional: SHA256_CTRL_ABORT_EN adds the abort input.
interface sha256_round_ctrl_if
  import sha256_pkg::*;
#(
  parameter int unsigned IDX_W = SHA256_IDX_W
) ();

  logic             in_valid;
  logic             in_first;
  logic             in_ready;
  logic             sched_load;
  logic             sched_en;
  logic [IDX_W-1:0] round_idx;
  logic             hash_init;
  logic             comp_en;
  logic [IDX_W-1:0] comp_idx;
  logic             digest_add;
  logic             out_valid;
  logic             out_ready;
`ifdef SHA256_CTRL_ABORT_EN
  logic             abort;

  modport master (
    input  in_valid, in_first, out_ready, abort,
    output in_ready, sched_load, sched_en, round_idx, hash_init,
           comp_en, comp_idx, digest_add, out_valid
  );

  modport slave (
    output in_valid, in_first, out_ready, abort,
    input  in_ready, sched_load, sched_en, round_idx, hash_init,
           comp_en, comp_idx, digest_add, out_valid
  );
`else
  modport master (
    input  in_valid, in_first, out_ready,
    output in_ready, sched_load, sched_en, round_idx, hash_init,
           comp_en, comp_idx, digest_add, out_valid
  );

  modport slave (
    output in_valid, in_first, out_ready,
    input  in_ready, sched_load, sched_en, round_idx, hash_init,
           comp_en, comp_idx, digest_add, out_valid
  );
`endif

endinterface

// File: rtl/sha256_round_ctrl_cnt.sv
// Round index counter for the SHA-256 controller.
//   clk, reset : clock, asynchronous active-high reset
//   i_clr      : synchronous clear (higher priority than i_en)
//   i_en       : advance; wraps to 0 after ROUNDS-1
//   o_cnt      : current round index
//   o_last     : o_cnt == ROUNDS-1
module sha256_round_cnt
  import sha256_pkg::*;
#(
  parameter int unsigned ROUNDS = SHA256_ROUNDS,
  parameter int unsigned IDX_W  = SHA256_IDX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [IDX_W-1:0] o_cnt,
  output logic             o_last
);

  logic [IDX_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == IDX_W'(ROUNDS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_last ? '0 : r_cnt + IDX_W'(1);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_last = w_last;

endmodule

// File: rtl/sha256_round_ctrl.sv
// Sequencer for one SHA-256 block: accepts a block, pulses the schedule
// parallel-load, steps the round index through the schedule stage, feeds the
// compression core a LAG-delayed copy, issues digest_add and holds out_valid
// until the consumer takes it.
//   clk   : single clock, rising edge
//   reset : asynchronous, active-high
//   bus   : sha256_round_ctrl_if.master (handshakes + datapath controls)
// Optional: SHA256_CTRL_ABORT_EN enables bus.abort (return to IDLE from any
// busy state, clearing the counters and delay line).
module sha256_round_ctrl
  import sha256_pkg::*;
#(
  parameter int unsigned ROUNDS = SHA256_ROUNDS,
  parameter int unsigned IDX_W  = SHA256_IDX_W,
  parameter int unsigned LAG    = SHA256_LAG
) (
  input  logic                 clk,
  input  logic                 reset,
  sha256_round_ctrl_if.master  bus
);

  localparam int unsigned DRN_W = (LAG > 1) ? $clog2(LAG) : 1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_first;
  logic [DRN_W-1:0] r_drn_cnt;
  logic             w_drn_last;
  logic             w_abort;

  logic [IDX_W-1:0] w_cnt;
  logic             w_cnt_last;

  logic             w_in_ready;
  logic             w_sched_load;
  logic             w_sched_en;
  logic             w_hash_init;
  logic             w_digest_add;
  logic             w_out_valid;

  logic [LAG-1:0]            r_dly_en;
  logic [LAG-1:0][IDX_W-1:0] r_dly_idx;

`ifdef SHA256_CTRL_ABORT_EN
  assign w_abort = bus.abort && (r_state != ST_IDLE);
`else
  assign w_abort = 1'b0;
`endif

  sha256_round_cnt #(
    .ROUNDS (ROUNDS),
    .IDX_W  (IDX_W)
  ) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_abort),
    .i_en   (r_state == ST_ROUNDS),
    .o_cnt  (w_cnt),
    .o_last (w_cnt_last)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; abort overrides everything, including out_ready in DONE
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:   if (bus.in_valid) w_state_nxt = ST_LOAD;
      ST_LOAD:   w_state_nxt = ST_ROUNDS;
      ST_ROUNDS: if (w_cnt_last) w_state_nxt = ST_DRAIN;
      ST_DRAIN:  if (w_drn_last) w_state_nxt = ST_FINAL;
      ST_FINAL:  w_state_nxt = ST_DONE;
      ST_DONE:   if (bus.out_ready) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
    if (w_abort) begin
      w_state_nxt = ST_IDLE;
    end
  end

  // Moore outputs
  always_comb begin
    w_in_ready   = 1'b0;
    w_sched_load = 1'b0;
    w_sched_en   = 1'b0;
    w_hash_init  = 1'b0;
    w_digest_add = 1'b0;
    w_out_valid  = 1'b0;
    unique case (r_state)
      ST_IDLE:   w_in_ready = 1'b1;
      ST_LOAD: begin
        w_sched_load = 1'b1;
        w_hash_init  = r_first;
      end
      ST_ROUNDS: w_sched_en = 1'b1;
      ST_FINAL:  w_digest_add = 1'b1;
      ST_DONE:   w_out_valid = 1'b1;
      default:   ;
    endcase
  end

  // in_first is captured on the accepting edge only
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_first <= 1'b0;
    end else if ((r_state == ST_IDLE) && bus.in_valid) begin
      r_first <= bus.in_first;
    end
  end

  // DRAIN length counter, idle at 0 outside DRAIN
  assign w_drn_last = (r_drn_cnt == DRN_W'(LAG - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_drn_cnt <= '0;
    end else if ((r_state == ST_DRAIN) && !w_drn_last && !w_abort) begin
      r_drn_cnt <= r_drn_cnt + DRN_W'(1);
    end else begin
      r_drn_cnt <= '0;
    end
  end

  // LAG-deep delay line aligning compression controls with registered Wi/Ki
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dly_en  <= '0;
      r_dly_idx <= '0;
    end else if (w_abort) begin
      r_dly_en  <= '0;
      r_dly_idx <= '0;
    end else begin
      r_dly_en[0]  <= w_sched_en;
      r_dly_idx[0] <= w_cnt;
      for (int unsigned i = 1; i < LAG; i++) begin
        r_dly_en[i]  <= r_dly_en[i-1];
        r_dly_idx[i] <= r_dly_idx[i-1];
      end
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.sched_load = w_sched_load;
  assign bus.sched_en   = w_sched_en;
  assign bus.round_idx  = w_cnt;
  assign bus.hash_init  = w_hash_init;
  assign bus.comp_en    = r_dly_en[LAG-1];
  assign bus.comp_idx   = r_dly_idx[LAG-1];
  assign bus.digest_add = w_digest_add;
  assign bus.out_valid  = w_out_valid;

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Directed bench for sha256_round_ctrl (defaults: ROUNDS=64, IDX_W=6, LAG=1).
// Cycle numbering: the accepting edge is cycle 0; samples are taken 1 time
// unit after each rising edge.
module tb_sha256_round_ctrl;

  typedef struct packed {
    logic       in_ready;
    logic       sched_load;
    logic       sched_en;
    logic       hash_init;
    logic       comp_en;
    logic       digest_add;
    logic       out_valid;
    logic [5:0] round_idx;
    logic [5:0] comp_idx;
  } obs_t;

  typedef struct {
    int    cyc;
    string name;
    obs_t  exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset;

  sha256_round_ctrl_if #(.IDX_W(6)) bus ();

  sha256_round_ctrl #(
    .ROUNDS (64),
    .IDX_W  (6),
    .LAG    (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  obs_t cur;
  obs_t idle_obs;
  obs_t trace [0:79];
  vec_t tbl [$];

  function automatic obs_t mk(logic ir, logic sl, logic se, logic hi, logic ce,
                              logic da, logic ov, logic [5:0] ri, logic [5:0] ci);
    obs_t o;
    o.in_ready   = ir;
    o.sched_load = sl;
    o.sched_en   = se;
    o.hash_init  = hi;
    o.comp_en    = ce;
    o.digest_add = da;
    o.out_valid  = ov;
    o.round_idx  = ri;
    o.comp_idx   = ci;
    return o;
  endfunction

  task automatic sample();
    cur.in_ready   = bus.in_ready;
    cur.sched_load = bus.sched_load;
    cur.sched_en   = bus.sched_en;
    cur.hash_init  = bus.hash_init;
    cur.comp_en    = bus.comp_en;
    cur.digest_add = bus.digest_add;
    cur.out_valid  = bus.out_valid;
    cur.round_idx  = bus.round_idx;
    cur.comp_idx   = bus.comp_idx;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    sample();
    cyc++;
  endtask

  task automatic chk(input string nm, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Present a block when in_ready is seen; returns in cycle 1 (LOAD expected)
  task automatic start_block(input logic first, input logic keep);
    int n = 0;
    while (!cur.in_ready && n < 200) begin
      step();
      n++;
    end
    chk_int("start_ready", int'(cur.in_ready), 1);
    trace[0] = cur;
    bus.in_valid = 1'b1;
    bus.in_first = first;
    step();
    cyc = 1;
    trace[1] = cur;
    if (!keep) bus.in_valid = 1'b0;
  endtask

  // Run until out_valid (bounded); report first digest_add and out_valid cycles
  task automatic wait_ov(output int t_da, output int t_ov);
    int n = 0;
    t_da = -1;
    while (!cur.out_valid && n < 300) begin
      step();
      if (cur.digest_add && t_da < 0) t_da = cyc;
      n++;
    end
    t_ov = cur.out_valid ? cyc : -1;
  endtask

  initial begin
    int t_da, t_ov, n, cnt;

    reset         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_first  = 1'b1;
    bus.out_ready = 1'b1;
`ifdef SHA256_CTRL_ABORT_EN
    bus.abort     = 1'b0;
`endif
    idle_obs = mk(1, 0, 0, 0, 0, 0, 0, 6'd0, 6'd0);

    // First block, in_first=1, out_ready=1
    tbl.push_back('{0,  "t1_pre_idle",  mk(1, 0, 0, 0, 0, 0, 0, 6'd0,  6'd0)});
    tbl.push_back('{1,  "t1_load",      mk(0, 1, 0, 1, 0, 0, 0, 6'd0,  6'd0)});
    tbl.push_back('{2,  "t1_round0",    mk(0, 0, 1, 0, 0, 0, 0, 6'd0,  6'd0)});
    tbl.push_back('{3,  "t1_round1",    mk(0, 0, 1, 0, 1, 0, 0, 6'd1,  6'd0)});
    tbl.push_back('{34, "t1_round32",   mk(0, 0, 1, 0, 1, 0, 0, 6'd32, 6'd31)});
    tbl.push_back('{65, "t1_round63",   mk(0, 0, 1, 0, 1, 0, 0, 6'd63, 6'd62)});
    tbl.push_back('{66, "t1_drain",     mk(0, 0, 0, 0, 1, 0, 0, 6'd0,  6'd63)});
    tbl.push_back('{67, "t1_final",     mk(0, 0, 0, 0, 0, 1, 0, 6'd0,  6'd0)});
    tbl.push_back('{68, "t1_done",      mk(0, 0, 0, 0, 0, 0, 1, 6'd0,  6'd0)});
    tbl.push_back('{69, "t1_idle_post", mk(1, 0, 0, 0, 0, 0, 0, 6'd0,  6'd0)});

    // Reset values, handshake during reset ignored
    #1;
    sample();
    chk("reset_state", cur, idle_obs);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.in_valid = 1'b0;
    step();
    chk("reset_ignore", cur, idle_obs);

    // 1: single first block, full trace
    start_block(1'b1, 1'b0);
    for (int c = 2; c <= 69; c++) begin
      step();
      trace[c] = cur;
    end
    foreach (tbl[i]) chk(tbl[i].name, trace[tbl[i].cyc], tbl[i].exp);
    for (int c = 2; c <= 65; c++)
      chk_int("t1_ridx", int'({trace[c].sched_en, trace[c].round_idx}), int'({1'b1, 6'(c - 2)}));
    for (int c = 3; c <= 66; c++)
      chk_int("t1_cidx", int'({trace[c].comp_en, trace[c].comp_idx}), int'({1'b1, 6'(c - 3)}));
    cnt = 0;
    for (int c = 0; c <= 69; c++) if (trace[c].digest_add) cnt++;
    chk_int("t1_dadd_count", cnt, 1);

    // 2: backpressure in DONE, non-first block
    bus.out_ready = 1'b0;
    start_block(1'b0, 1'b0);
    chk_int("t2_load_noinit", int'({cur.sched_load, cur.hash_init}), 2);
    wait_ov(t_da, t_ov);
    chk_int("t2_dadd_cyc", t_da, 67);
    chk_int("t2_ov_cyc", t_ov, 68);
    for (int k = 0; k < 10; k++) begin
      step();
      chk_int("t2_hold", int'({cur.out_valid, cur.in_ready}), 2);
    end
    bus.out_ready = 1'b1;
    step();
    chk_int("t2_release", int'({cur.out_valid, cur.in_ready}), 1);

    // 3: back-to-back, second block in_first=0
    start_block(1'b1, 1'b1);
    bus.in_first = 1'b0;
    wait_ov(t_da, t_ov);
    chk_int("t3_ov1_cyc", t_ov, 68);
    step();
    chk_int("t3_gap_idle", int'({cur.in_ready, cur.sched_load}), 2);
    step();
    chk_int("t3_load2", int'({cur.sched_load, cur.hash_init, cur.in_ready}), 4);
    bus.in_valid = 1'b0;
    wait_ov(t_da, t_ov);
    chk_int("t3_ov2_cyc", t_ov, 137);
    step();

    // 4: in_valid during ROUNDS ignored until IDLE
    start_block(1'b0, 1'b0);
    n = 0;
    while (!(cur.sched_en && cur.round_idx == 6'd20) && n < 100) begin
      step();
      n++;
    end
    chk_int("t4_r20_cyc", cyc, 22);
    bus.in_valid = 1'b1;
    bus.in_first = 1'b1;
    step();
    chk_int("t4_ignored", int'({cur.in_ready, cur.sched_load, cur.sched_en, cur.round_idx}), int'({3'b001, 6'd21}));
    n = 0;
    while (!cur.sched_load && n < 200) begin
      step();
      n++;
    end
    chk_int("t4_accept_cyc", cyc, 70);
    chk_int("t4_hash_init", int'(cur.hash_init), 1);
    bus.in_valid = 1'b0;
    wait_ov(t_da, t_ov);
    step();

    // 5: asynchronous reset mid-block
    start_block(1'b0, 1'b0);
    n = 0;
    while (!(cur.sched_en && cur.round_idx == 6'd30) && n < 100) begin
      step();
      n++;
    end
    chk_int("t5_r30_cyc", cyc, 32);
    #1 reset = 1'b1;
    #1 sample();
    chk("t5_async_reset", cur, idle_obs);
    step();
    chk("t5_reset_held", cur, idle_obs);
    reset = 1'b0;
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (cur.digest_add || cur.out_valid || cur.comp_en) cnt++;
    end
    chk_int("t5_no_residue", cnt, 0);
    start_block(1'b1, 1'b0);
    chk_int("t5_load", int'({cur.sched_load, cur.hash_init}), 3);
    wait_ov(t_da, t_ov);
    chk_int("t5_dadd_cyc", t_da, 67);
    chk_int("t5_ov_cyc", t_ov, 68);
    step();

`ifdef SHA256_CTRL_ABORT_EN
    // 6: abort during ROUNDS
    start_block(1'b1, 1'b0);
    n = 0;
    while (!(cur.sched_en && cur.round_idx == 6'd40) && n < 100) begin
      step();
      n++;
    end
    chk_int("t6_r40_cyc", cyc, 42);
    bus.abort = 1'b1;
    step();
    chk("t6_abort_idle", cur, idle_obs);
    bus.abort = 1'b0;
    cnt = 0;
    for (int k = 0; k < 80; k++) begin
      step();
      if (cur.digest_add || cur.out_valid || cur.comp_en || !cur.in_ready) cnt++;
    end
    chk_int("t6_no_residue", cnt, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
